// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle multiply/divide unit that owns the HI/LO register pair of the
// 5-stage MIPS pipeline. An op issued from EX is latched as sign flags plus
// operand magnitudes. One radix-2 step (shift-add multiply or restoring
// divide) then runs per cycle for WIDTH cycles. Sign correction is applied
// and HI/LO are written in a final FINISH cycle.
//
// Ports
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous active-high reset
//   Start      in   EX holds mult/multu/div/divu this cycle
//   Op         in   00 mult, 01 multu, 10 div, 11 divu
//   OperandA   in   multiplicand / dividend (rs after forwarding)
//   OperandB   in   multiplier / divisor (rt after forwarding)
//   HiLoRead   in   EX holds mfhi/mflo this cycle
//   Stall      out  combinational pipeline freeze request
//   Busy       out  operation in flight
//   Done       out  one-cycle pulse after HI/LO are written
//   DivByZero  out  valid with Done; divide with OperandB == 0
//   HI         out  product upper half / remainder
//   LO         out  product lower half / quotient
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             HiLoRead,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      count_q;
    logic               is_div_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic [WIDTH-1:0]   mag_a_q;
    logic [WIDTH-1:0]   mag_b_q;
    // Multiply: {partial product upper, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               dbz_q;

    logic               sign_a_in;
    logic               sign_b_in;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH:0]   div_shift;
    logic [WIDTH:0]     div_top;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] acc_d;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               dbz_d;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    // Operand capture: unsigned ops (Op[0]=1) never flag a sign.
    always_comb begin
        sign_a_in = ~Op[0] & OperandA[WIDTH-1];
        sign_b_in = ~Op[0] & OperandB[WIDTH-1];
        mag_a_in  = sign_a_in ? -OperandA : OperandA;
        mag_b_in  = sign_b_in ? -OperandB : OperandB;
    end

    // One radix-2 iteration.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};

        // The shifted remainder needs WIDTH+1 bits; it is always < 2*|B|.
        div_shift = {acc_q, 1'b0};
        div_top   = div_shift[2*WIDTH:WIDTH];
        div_diff  = div_top - {1'b0, mag_b_q};
        if (div_top >= {1'b0, mag_b_q}) begin
            div_step = {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
        end else begin
            div_step = div_shift[2*WIDTH-1:0];
        end

        acc_d = is_div_q ? div_step : mul_step;
    end

    // Sign correction and final HI/LO values.
    always_comb begin
        prod  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quot  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem   = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        dbz_d = is_div_q && (mag_b_q == '0);
        if (!is_div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
        end else if (dbz_d) begin
            // Rebuild the raw dividend from sign and magnitude.
            hi_d = sign_a_q ? -mag_a_q : mag_a_q;
            lo_d = '1;
        end else begin
            hi_d = rem;
            lo_d = quot;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        is_div_q <= Op[1];
                        sign_a_q <= sign_a_in;
                        sign_b_q <= sign_b_in;
                        mag_a_q  <= mag_a_in;
                        mag_b_q  <= mag_b_in;
                        acc_q    <= Op[1] ? {{WIDTH{1'b0}}, mag_a_in}
                                          : {{WIDTH{1'b0}}, mag_b_in};
                        count_q  <= CW'(WIDTH - 1);
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == '0) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    dbz_q   <= dbz_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy      = (state_q != IDLE);
    assign Stall     = Busy & (HiLoRead | Start);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Self-checking bench for muldiv_sequencer: table of directed vectors plus
// model-checked random ops, scoreboard queue popped on Done, and hand-written
// stall/back-to-back and mid-run reset sequences.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int unsigned W = 32;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] OperandA;
    logic [W-1:0] OperandB;
    logic         HiLoRead;
    logic         Stall;
    logic         Busy;
    logic         Done;
    logic         DivByZero;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        string       name;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        string       name;
    } vec_t;

    exp_t sb_q[$];

    muldiv_sequencer #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .HiLoRead  (HiLoRead),
        .Stall     (Stall),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .HI        (HI),
        .LO        (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_result(input logic [31:0] hi, input logic [31:0] lo,
                                 input logic dbz, input string name);
        exp_t e;
        e.hi   = hi;
        e.lo   = lo;
        e.dbz  = dbz;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Reference model using 64-bit language arithmetic.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa  = $signed(a);
        sb  = $signed(b);
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        case (op)
            2'b00: begin
                p  = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    hi = a; lo = '1; dbz = 1'b1;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = '1; dbz = 1'b1;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endtask

    // Scoreboard: every Done pops one expected result.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (Done) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL done_without_op: scoreboard size 0, required >= 1");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check({e.name, "_hi"},  64'(HI),        64'(e.hi));
                    check({e.name, "_lo"},  64'(LO),        64'(e.lo));
                    check({e.name, "_dbz"}, 64'(DivByZero), 64'(e.dbz));
                end
            end else begin
                check("dbz_outside_done", 64'(DivByZero), 64'd0);
            end
        end
    end

    // Issue one op, scramble inputs after acceptance, and check Busy, HI/LO hold
    // and a fixed 34-cycle Start-to-Done latency.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi_e, input logic [31:0] lo_e,
                          input logic dbz_e, input string name);
        logic [31:0] h0;
        logic [31:0] l0;
        int          cyc;
        @(negedge Clk);
        Start    = 1'b1;
        Op       = op;
        OperandA = a;
        OperandB = b;
        expect_result(hi_e, lo_e, dbz_e, name);
        h0 = HI;
        l0 = LO;
        @(negedge Clk);
        Start    = 1'b0;
        Op       = 2'($urandom);
        OperandA = $urandom;
        OperandB = $urandom;
        cyc = 1;
        while (!Done && cyc < 100) begin
            check({name, "_busy"},    64'(Busy), 64'd1);
            check({name, "_hi_hold"}, 64'(HI),   64'(h0));
            check({name, "_lo_hold"}, 64'(LO),   64'(l0));
            @(negedge Clk);
            cyc++;
        end
        check({name, "_latency"},   64'(cyc),  64'd34);
        check({name, "_busy_done"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[12];
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rhi;
        logic [31:0] rlo;
        logic        rdbz;
        int          cyc;

        vecs = '{
            '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_7_m3"},
            '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"},
            '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_min_min"},
            '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2"},
            '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, "divu_100_7"},
            '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_min_m1"},
            '{2'b11, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, "divu_5_0"},
            '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, "div_m7_0"},
            '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_7_m2"},
            '{2'b01, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b0, "multu_min_2"},
            '{2'b00, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000, 1'b0, "mult_min_2"},
            '{2'b11, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, "divu_max_1"}
        };

        Reset    = 1'b1;
        Start    = 1'b0;
        Op       = 2'b00;
        OperandA = '0;
        OperandB = '0;
        HiLoRead = 1'b1;
        #12;
        check("rst_hi",    64'(HI),        64'd0);
        check("rst_lo",    64'(LO),        64'd0);
        check("rst_busy",  64'(Busy),      64'd0);
        check("rst_done",  64'(Done),      64'd0);
        check("rst_dbz",   64'(DivByZero), 64'd0);
        check("rst_stall", 64'(Stall),     64'd0);
        @(negedge Clk);
        Reset    = 1'b0;
        HiLoRead = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   vecs[i].dbz, vecs[i].name);
        end

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            if (i == 4) rb = rb >> 20;
            model(rop, ra, rb, rhi, rlo, rdbz);
            run_op(rop, ra, rb, rhi, rlo, rdbz, "random");
        end

        // HiLoRead from RUN cycle 5, plus a second op presented during RUN
        // and held until it is accepted in the first op's Done cycle.
        @(negedge Clk);
        Start    = 1'b1;
        Op       = 2'b11;
        OperandA = 32'd100;
        OperandB = 32'd7;
        expect_result(32'd2, 32'd14, 1'b0, "stall_divu");
        @(negedge Clk);
        Start = 1'b0;
        cyc   = 1;
        while (!Done && cyc < 100) begin
            if (cyc >= 6) check("stall_run", 64'(Stall), 64'd1);
            if (cyc == 5) HiLoRead = 1'b1;
            if (cyc == 10) begin
                Start    = 1'b1;
                Op       = 2'b00;
                OperandA = 32'd3;
                OperandB = 32'd5;
                expect_result(32'd0, 32'd15, 1'b0, "second_mult");
            end
            @(negedge Clk);
            cyc++;
        end
        check("stall_latency",    64'(cyc),   64'd34);
        check("stall_done_cycle", 64'(Stall), 64'd0);
        @(negedge Clk);
        check("second_busy",  64'(Busy),  64'd1);
        check("second_stall", 64'(Stall), 64'd1);
        Start    = 1'b0;
        HiLoRead = 1'b0;
        OperandA = $urandom;
        OperandB = $urandom;
        cyc = 1;
        while (!Done && cyc < 100) begin
            @(negedge Clk);
            cyc++;
        end
        check("second_latency", 64'(cyc), 64'd34);

        // Asynchronous reset in RUN cycle 10 discards the op.
        @(negedge Clk);
        Start    = 1'b1;
        Op       = 2'b00;
        OperandA = 32'd7;
        OperandB = 32'd9;
        @(negedge Clk);
        Start    = 1'b0;
        HiLoRead = 1'b1;
        for (int i = 1; i < 10; i++) @(negedge Clk);
        check("pre_reset_stall", 64'(Stall), 64'd1);
        check("pre_reset_lo",    64'(LO),    64'd15);
        #2 Reset = 1'b1;
        #1;
        check("arst_hi",    64'(HI),    64'd0);
        check("arst_lo",    64'(LO),    64'd0);
        check("arst_busy",  64'(Busy),  64'd0);
        check("arst_stall", 64'(Stall), 64'd0);
        check("arst_done",  64'(Done),  64'd0);
        @(negedge Clk);
        Reset    = 1'b0;
        HiLoRead = 1'b0;
        check("post_reset_busy", 64'(Busy), 64'd0);
        run_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "after_reset_mult");

        @(negedge Clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller that owns the HI/LO register pair for the 5-stage MIPS pipeline.
- Accepts a mult/multu/div/divu issued from the EX stage and runs one radix-2 iteration per cycle (shift-add or restoring divide) for WIDTH cycles.
- Writes HI/LO once the operation completes.
- Drives a stall request to the hazard logic whenever a later instruction needs HI/LO, or issues another mul/div, while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- Clk  in  1  clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  EX stage holds a mul/div op this cycle.
- Op  in  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- OperandA  in  WIDTH  rs value after forwarding; multiplicand or dividend.
- OperandB  in  WIDTH  rt value after forwarding; multiplier or divisor.
- HiLoRead  in  1  EX stage holds mfhi/mflo this cycle.
- Stall  out  1  combinational; freeze PC, IF/ID and ID/EX, and bubble EX/MEM.
- Busy  out  1  operation in flight.
- Done  out  1  one-cycle pulse; HI/LO were just updated.
- DivByZero  out  1  valid with Done; set only for div/divu with OperandB==0.
- HI  out  WIDTH  HI register (product upper half / remainder).
- LO  out  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset is asynchronous; all outputs and state clear immediately:
  - state=IDLE, HI=LO=0, Done=DivByZero=0, Busy=0, counter=0.
  - Any in-flight operation is discarded; HI/LO are not written.
- States: IDLE, RUN, FINISH.
- IDLE:
  - Start=1 at an edge latches Op, sign flags and magnitudes |A| and |B| (unsigned ops use raw values), sets counter=WIDTH-1, and moves to RUN.
  - Start=0 keeps IDLE with HI/LO held.
- RUN:
  - One iteration per edge.
  - Multiply: 2*WIDTH-bit accumulator, add-and-shift on the multiplier LSB.
  - Divide: restoring shift-subtract of the remainder against |B|.
  - counter decrements each edge; at the edge where counter==0 the state moves to FINISH.
- FINISH:
  - At the next edge, apply sign correction, write HI/LO, set Done=1 (and DivByZero if applicable) for exactly one cycle, and return to IDLE.
- Latency: Start sampled at edge E0, then RUN for edges E1..E32, then HI/LO written at edge E33. Done is high in the cycle after E33. Fixed WIDTH+1 edges for every op, including divide-by-zero.
- Busy = (state != IDLE).
- Stall = Busy & (HiLoRead | Start). It is deasserted in the Done cycle, so mfhi/mflo issued then reads the new HI/LO with no bypass needed.
- Start while Busy is ignored. Stall holds the instruction in EX, so it is re-presented and accepted once IDLE.
- Start and Done in the same cycle: Start is accepted, since state is already IDLE.
- Signed multiply: the full 2*WIDTH two's-complement product is negated if signA^signB. HI = upper word, LO = lower word.
- Signed divide:
  - Quotient is negated if signA^signB; remainder takes signA.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0 (wrap, no trap).
- Divide by zero (B==0): HI=OperandA unmodified, LO=all ones, DivByZero=1 with Done.
- HI/LO change only at the FINISH edge or on reset; no partial results are visible.
- Op and operand changes on the inputs after the Start edge have no effect.

Test Plan:
- mult 7 x 0xFFFFFFFD (-3): Done pulses exactly 34 cycles after Start; HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy=1 for cycles 1..33.
- multu 0xFFFFFFFF x 0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001. mult 0x80000000 x 0x80000000: HI=0x40000000, LO=0.
- div 0xFFFFFFF9 (-7) / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7: LO=0x0000000E, HI=0x00000002. div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- divu 5/0: HI=0x00000005, LO=0xFFFFFFFF, DivByZero=1 only in the Done cycle; latency unchanged (34).
- HiLoRead=1 from cycle 5 of RUN: Stall=1 each cycle until Done, Stall=0 in the Done cycle with HI/LO updated. A second Start during RUN leaves Stall=1 and the first result unaffected; the second op starts in the Done cycle.
- Reset pulsed mid-edge in RUN cycle 10: HI=LO=0, Busy=Stall=Done=0 immediately without a clock. After release, Start with mult 3x4 produces LO=12, HI=0 after 34 cycles.
